// File: rtl/hue_pkg.sv
// Shared types and per-phase lookups for the hue wheel controller.
// The phase rule table lives here so that the top and any checker use the same encoding.
package hue_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} ctrl_state_t;

  typedef enum logic [2:0] {PH_0, PH_1, PH_2, PH_3, PH_4, PH_5} phase_t;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  // Channel that moves during a phase: G up, R down, B up, G down, R up, B down.
  function automatic logic [1:0] phase_chan(input phase_t p);
    case (p)
      PH_0, PH_3: phase_chan = CH_G;
      PH_1, PH_4: phase_chan = CH_R;
      default:    phase_chan = CH_B;
    endcase
  endfunction

  function automatic logic phase_up(input phase_t p);
    case (p)
      PH_0, PH_2, PH_4: phase_up = 1'b1;
      default:          phase_up = 1'b0;
    endcase
  endfunction

  function automatic phase_t phase_next(input phase_t p);
    case (p)
      PH_0:    phase_next = PH_1;
      PH_1:    phase_next = PH_2;
      PH_2:    phase_next = PH_3;
      PH_3:    phase_next = PH_4;
      PH_4:    phase_next = PH_5;
      default: phase_next = PH_0;
    endcase
  endfunction

endpackage

// File: rtl/hue_cycle_ctrl_if.sv
// Bundle between the button/enable logic (master) and the hue controller (slave).
// Handshake: en/hold are level requests sampled every clk; all outputs are registered levels, wrap is a 1-cycle pulse.
interface hue_cycle_ctrl_if #(
  parameter int DW = 11
);
  import hue_pkg::*;

  logic          en;
  logic          hold;
  logic [2:0]    phase;
  logic          wrap;
  logic [DW-1:0] duty_r;
  logic [DW-1:0] duty_g;
  logic [DW-1:0] duty_b;
  logic          pwm_r;
  logic          pwm_g;
  logic          pwm_b;
  ctrl_state_t   state;

  modport master (
    output en, hold,
    input  phase, wrap, duty_r, duty_g, duty_b, pwm_r, pwm_g, pwm_b, state
  );

  modport slave (
    input  en, hold,
    output phase, wrap, duty_r, duty_g, duty_b, pwm_r, pwm_g, pwm_b, state
  );

endinterface

// File: rtl/pwm_gen.sv
// Shared PWM counter, wrap-aligned shadow duty registers and registered comparators.
// GAMMA_EN: when defined, shadows load a registered (duty*duty)/PWM_INTERVAL instead of linear duty.
module pwm_gen #(
  parameter int PWM_INTERVAL = 1200,
  parameter int DW = $clog2(PWM_INTERVAL + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0][DW-1:0]  duty_nxt,
  output logic [2:0]          pwm
);

  localparam int CW = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PWM_INTERVAL - 1);

  logic [CW-1:0]        pwm_cnt;
  logic [2:0][DW-1:0]   shadow;
  logic [2:0][DW-1:0]   load_src;
  logic                 load;

  assign load = (pwm_cnt == CNT_LAST);

`ifdef GAMMA_EN
  localparam logic [2*DW-1:0] DIV = (2*DW)'(PWM_INTERVAL);

  logic [2:0][2*DW-1:0] prod;
  logic [2:0][DW-1:0]   gamma_d;
  logic [2:0][DW-1:0]   gamma_q;

  always_comb begin
    prod    = '0;
    gamma_d = '0;
    for (int i = 0; i < 3; i++) begin
      prod[i]    = (2*DW)'(duty_nxt[i]) * (2*DW)'(duty_nxt[i]);
      gamma_d[i] = DW'(prod[i] / DIV);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) gamma_q <= '0;
    else     gamma_q <= gamma_d;
  end

  assign load_src = gamma_q;
`else
  assign load_src = duty_nxt;
`endif

  // Shadows only change at the period boundary, so a period never mixes two duties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      shadow  <= '0;
      pwm     <= '0;
    end else begin
      pwm_cnt <= load ? '0 : pwm_cnt + 1'b1;
      if (load) shadow <= load_src;
      for (int i = 0; i < 3; i++) pwm[i] <= (DW'(pwm_cnt) < shadow[i]);
    end
  end

endmodule

// File: rtl/hue_cycle_ctrl.sv
// Hue wheel sequencer: run/pause FSM, step timer and per-phase duty arithmetic driving a shared PWM.
// GAMMA_EN (optional define) selects gamma-corrected shadow loading inside pwm_gen.
module hue_cycle_ctrl
  import hue_pkg::*;
#(
  parameter int PWM_INTERVAL    = 1200,
  parameter int STEPS_PER_PHASE = 6,
  parameter int STEP_INTERVAL   = 333333,
  parameter int DUTY_STEP       = PWM_INTERVAL / STEPS_PER_PHASE
) (
  input logic            clk,
  input logic            rst,
  hue_cycle_ctrl_if.slave bus
);

  localparam int DW  = $clog2(PWM_INTERVAL + 1);
  localparam int SCW = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam int SIW = (STEPS_PER_PHASE > 1) ? $clog2(STEPS_PER_PHASE) : 1;

  localparam logic [DW-1:0]  FULL    = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0]  STEP    = DW'(DUTY_STEP);
  localparam logic [SCW-1:0] SC_LAST = SCW'(STEP_INTERVAL - 1);
  localparam logic [SIW-1:0] SI_LAST = SIW'(STEPS_PER_PHASE - 1);

  ctrl_state_t        state;
  phase_t             phase;
  logic [SIW-1:0]     step_idx;
  logic [SCW-1:0]     step_cnt;
  logic               wrap;
  logic [2:0][DW-1:0] duty;
  logic [2:0][DW-1:0] duty_nxt;
  logic               tick;
  logic               last_step;
  logic [1:0]         ch;
  logic               up;
  logic [2:0]         pwm;

  assign tick      = (state == RUN) && bus.en && !bus.hold && (step_cnt == SC_LAST);
  assign last_step = (step_idx == SI_LAST);
  assign ch        = phase_chan(phase);
  assign up        = phase_up(phase);

  // Duty next-state is also what the PWM shadows sample, so a tick on a wrap cycle is not lost.
  always_comb begin
    duty_nxt = duty;
    case (state)
      IDLE: begin
        duty_nxt = '0;
        if (bus.en) duty_nxt[CH_R] = FULL;
      end
      default: begin
        if (!bus.en) begin
          duty_nxt = '0;
        end else if (tick) begin
          if (last_step)  duty_nxt[ch] = up ? FULL : '0;
          else if (up)    duty_nxt[ch] = (duty[ch] > FULL - STEP) ? FULL : duty[ch] + STEP;
          else            duty_nxt[ch] = (duty[ch] < STEP) ? '0 : duty[ch] - STEP;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= PH_0;
      step_idx <= '0;
      step_cnt <= '0;
      duty     <= '0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      duty <= duty_nxt;
      case (state)
        IDLE: begin
          step_cnt <= '0;
          step_idx <= '0;
          if (bus.en) begin
            state <= RUN;
            phase <= PH_0;
          end
        end
        RUN: begin
          if (!bus.en) begin
            state <= IDLE;
          end else if (bus.hold) begin
            state <= PAUSE;
          end else if (tick) begin
            step_cnt <= '0;
            if (last_step) begin
              step_idx <= '0;
              phase    <= phase_next(phase);
              wrap     <= (phase == PH_5);
            end else begin
              step_idx <= step_idx + 1'b1;
            end
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        PAUSE: begin
          if (!bus.en)       state <= IDLE;
          else if (!bus.hold) state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  pwm_gen #(
    .PWM_INTERVAL (PWM_INTERVAL),
    .DW           (DW)
  ) u_pwm (
    .clk      (clk),
    .rst      (rst),
    .duty_nxt (duty_nxt),
    .pwm      (pwm)
  );

  assign bus.phase  = phase;
  assign bus.wrap   = wrap;
  assign bus.duty_r = duty[CH_R];
  assign bus.duty_g = duty[CH_G];
  assign bus.duty_b = duty[CH_B];
  assign bus.pwm_r  = pwm[CH_R];
  assign bus.pwm_g  = pwm[CH_G];
  assign bus.pwm_b  = pwm[CH_B];
  assign bus.state  = state;

endmodule

// File: tb/tb_hue_cycle_ctrl.sv
// Directed bench for hue_cycle_ctrl with a small wheel (PWM 12, 3 steps/phase, 4 clk/step).
// Expected values are hand-derived; GAMMA_EN changes only the expected PWM high counts.
module tb_hue_cycle_ctrl;
  import hue_pkg::*;

  localparam int PI  = 12;
  localparam int SPP = 3;
  localparam int SI  = 4;
  localparam int DS  = 4;
  localparam int DW  = 4;

  // clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hue_cycle_ctrl_if #(.DW(DW)) bus ();

  hue_cycle_ctrl #(
    .PWM_INTERVAL    (PI),
    .STEPS_PER_PHASE (SPP),
    .STEP_INTERVAL   (SI),
    .DUTY_STEP       (DS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int wrap_cnt = 0;
  logic [DW-1:0] exp_q[$];
  int hi_r, hi_g, hi_b;

  always @(negedge clk) if (bus.wrap === 1'b1) wrap_cnt++;

  function automatic int exp_hi(input int d);
`ifdef GAMMA_EN
    return (d * d) / PI;
`else
    return d;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_hi(output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    repeat (PI) begin
      tick(1);
      r += int'(bus.pwm_r);
      g += int'(bus.pwm_g);
      b += int'(bus.pwm_b);
    end
  endtask

  task automatic check_duty(input string tag, input int r, input int g, input int b);
    check({tag, "_r"}, 32'(bus.duty_r), r);
    check({tag, "_g"}, 32'(bus.duty_g), g);
    check({tag, "_b"}, 32'(bus.duty_b), b);
  endtask

  initial begin
    bus.en   = 1'b0;
    bus.hold = 1'b0;

    // 1: reset, then idle with en low
    tick(3);
    check_duty("rst_duty", 0, 0, 0);
    check("rst_pwm", {bus.pwm_r, bus.pwm_g, bus.pwm_b}, 0);
    check("rst_phase", bus.phase, 0);
    check("rst_wrap", bus.wrap, 0);
    check("rst_state", bus.state, IDLE);
    rst = 1'b0;
    wrap_cnt = 0;
    tick(38);
    count_hi(hi_r, hi_g, hi_b);
    check("idle_pwm_hi", hi_r + hi_g + hi_b, 0);
    check_duty("idle_duty", 0, 0, 0);
    check("idle_phase", bus.phase, 0);
    check("idle_wrap_cnt", wrap_cnt, 0);

    // 2: run, first phase and a full wheel
    bus.en = 1'b1;
    tick(1);
    check("run_state", bus.state, RUN);
    check_duty("run_start", 12, 0, 0);
    check("run_phase", bus.phase, 0);
    exp_q.push_back(4'd4);
    exp_q.push_back(4'd8);
    exp_q.push_back(4'd12);
    for (int k = 0; k < SPP; k++) begin
      tick(SI);
      check("g_rise", 32'(bus.duty_g), 32'(exp_q.pop_front()));
    end
    check("phase_1", bus.phase, 1);
    tick(60);
    check("wheel_wrap", bus.wrap, 1);
    check("wheel_phase", bus.phase, 0);
    check_duty("wheel_end", 12, 0, 0);
    tick(1);
    check("wrap_pulse_end", bus.wrap, 0);
    check("wrap_once", wrap_cnt, 1);

    // 3: pause in phase 1 at R=8
    tick(15);
    check("ph1_phase", bus.phase, 1);
    check_duty("ph1_step", 8, 12, 0);
    bus.hold = 1'b1;
    tick(20);
    check("pause_state", bus.state, PAUSE);
    count_hi(hi_r, hi_g, hi_b);
    check("pause_pwm_r", hi_r, exp_hi(8));
    check("pause_pwm_g", hi_g, exp_hi(12));
    check("pause_pwm_b", hi_b, 0);
    tick(8);
    check_duty("pause_frozen", 8, 12, 0);
    check("pause_phase", bus.phase, 1);
    bus.hold = 1'b0;
    tick(4);
    check("resume_wait", 32'(bus.duty_r), 8);
    tick(1);
    check("resume_step", 32'(bus.duty_r), 4);

    // 4: drop en mid phase 3 while holding
    tick(20);
    check("ph3_phase", bus.phase, 3);
    check_duty("ph3_step", 0, 8, 12);
    bus.en   = 1'b0;
    bus.hold = 1'b1;
    tick(1);
    check("drop_state", bus.state, IDLE);
    check_duty("drop_duty", 0, 0, 0);
    tick(15);
    count_hi(hi_r, hi_g, hi_b);
    check("drop_pwm_hi", hi_r + hi_g + hi_b, 0);
    bus.hold = 1'b0;
    bus.en   = 1'b1;
    tick(1);
    check("reen_state", bus.state, RUN);
    check("reen_phase", bus.phase, 0);
    check_duty("reen_duty", 12, 0, 0);

    // 5: async reset between edges
    tick(15);
    check("pre_rst_pwm_r", bus.pwm_r, 1);
    check("pre_rst_pwm_g", bus.pwm_g, 0);
    #2 rst = 1'b1;
    #1;
    check_duty("arst_duty", 0, 0, 0);
    check("arst_pwm", {bus.pwm_r, bus.pwm_g, bus.pwm_b}, 0);
    check("arst_state", bus.state, IDLE);
    check("arst_phase", bus.phase, 0);
    bus.en = 1'b0;
    tick(2);
    rst = 1'b0;
    count_hi(hi_r, hi_g, hi_b);
    check("post_rst_pwm_hi", hi_r + hi_g + hi_b, 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
